// File: rtl/mem_stall_requester_if.sv
// rtl/mem_stall_requester_if.sv - req/ack data bus between the MEM-stage requester and memory
interface mem_stall_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [3:0]            bus_sel;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_ack;
    logic [DATA_WIDTH-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stall_requester.sv
// rtl/mem_stall_requester.sv - MEM-stage bus access unit with pipeline stall and bus timeout
module mem_stall_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [3:0]            mem_sel,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stall_all,
    output logic                  bus_error,
    mem_stall_requester_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic                  err_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic start;
    logic ack_hit;
    logic tmo_hit;

    // State register; reset abandons any outstanding request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the stall request; ack takes priority over the timeout.
    always_comb begin
        state_d   = state_q;
        stall_all = 1'b0;
        start     = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en && !flush) begin
                    start     = 1'b1;
                    stall_all = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_all = 1'b1;
                if (bus.bus_ack) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, timeout counter, error flag and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                we_q    <= mem_we;
                sel_q   <= mem_sel;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (state_q == DONE) begin
                err_q <= 1'b0;
            end
            if (ack_hit && !we_q) begin
                rdata_q <= bus.bus_rdata;
            end else if (tmo_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign bus.bus_req   = (state_q == BUSY);
    assign bus.bus_we    = we_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign read_data     = rdata_q;
    assign bus_error     = (state_q == DONE) && err_q;
endmodule
